// File: rtl/arb_selector_pkg.sv
// arb_selector_pkg: shared level/direction constants and index-width helper for the arbiter
package arb_selector_pkg;
  localparam bit HIGH = 1'b1;
  localparam bit LOW = 1'b0;
  localparam bit ENABLE = 1'b1;
  localparam bit DISABLE = 1'b0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_selector_grant_gen.sv
// arb_grant_gen: combinational one-hot grant and binary index from requests and round-robin pointer
module arb_grant_gen
  import arb_selector_pkg::*;
#(
  parameter int IN = 4,
  parameter bit MSB = ENABLE,
  parameter bit MODE = HIGH,
  localparam int IDX_W = idx_w(IN)
) (
  input  logic [IN-1:0]    req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IN-1:0]    grant,
  output logic [IDX_W-1:0] idx
);
  logic [IN-1:0] keep;
  logic [2*IN-1:0] dbl;
  int pos;
  // The masked copy covers the lanes from the pointer onward; the full copy supplies the wrap
  always_comb begin
    keep = '1;
    pos = 0;
    for (int i = 0; i < IN; i++) keep[i] = MODE ? (MSB ? (i <= int'(ptr)) : (i >= int'(ptr))) : 1'b1;
    dbl = MSB ? {req & keep, req} : {req, req & keep};
    for (int i = 0; i < 2*IN; i++) if (MSB ? dbl[i] : dbl[2*IN-1-i]) pos = MSB ? i : 2*IN-1-i;
    idx = IDX_W'(pos >= IN ? pos - IN : pos);
    grant = |req ? IN'(1) << idx : '0;
  end
endmodule

// File: rtl/arb_selector.sv
// arb_selector: registered N-to-1 arbitrated selector with valid/ready on every lane and the output
module arb_selector
  import arb_selector_pkg::*;
#(
  parameter int DATA = 32,
  parameter int IN = 4,
  parameter bit ACT = HIGH,
  parameter bit MSB = ENABLE,
  parameter bit MODE = HIGH,
  localparam int IDX_W = idx_w(IN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN-1:0]        in_valid,
  input  logic [DATA*IN-1:0]   in_data,
  output logic [IN-1:0]        in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA-1:0]      out_data,
  output logic [IN-1:0]        out_pos,
  output logic [IDX_W-1:0]     out_idx
);
  logic [IN-1:0] req, grant, out_pos_d, out_pos_q;
  logic [IDX_W-1:0] idx, out_idx_d, out_idx_q, ptr_d, ptr_q;
  logic [DATA-1:0] out_data_d, out_data_q;
  logic out_valid_d, out_valid_q, load, xfer;
  assign req = ACT ? in_valid : ~in_valid;
  assign load = ~out_valid_q | out_ready;
  arb_grant_gen #(.IN(IN), .MSB(MSB), .MODE(MODE)) u_grant (
    .req(req), .ptr(ptr_q), .grant(grant), .idx(idx)
  );
  always_comb begin
    xfer = ~reset & load & |req;
    in_ready = xfer ? grant : '0;
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d = xfer ? in_data[DATA*int'(idx) +: DATA] : out_data_q;
    out_pos_d = xfer ? grant : out_pos_q;
    out_idx_d = xfer ? idx : out_idx_q;
    ptr_d = MODE && xfer ? (MSB ? (idx == '0 ? IDX_W'(IN-1) : idx - 1'b1)
                                : (idx == IDX_W'(IN-1) ? '0 : idx + 1'b1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_pos_q <= '0;
      out_idx_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_pos_q <= out_pos_d;
      out_idx_q <= out_idx_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_pos = out_pos_q;
  assign out_idx = out_idx_q;
endmodule

// File: tb/tb_arb_selector.sv
// tb_arb_selector: hand vectors plus randomized traffic on three arbiter configurations against a reference model
module tb_arb_selector;
  import arb_selector_pkg::*;
  typedef struct {
    int inst;
    bit rst;
    logic [3:0] v;
    bit rdy;
    logic [3:0] eir;
    bit eov;
    logic [31:0] ed;
    logic [3:0] epos;
    logic [1:0] eidx;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] in_valid;
  logic [127:0] in_data;
  logic out_ready;
  logic [3:0] ir [3];
  logic ov [3];
  logic [31:0] od [3];
  logic [3:0] op [3];
  logic [1:0] oi [3];
  int nvec = 0, nmis = 0;
  bit act [3] = '{1'b1, 1'b1, 1'b0};
  bit msb [3] = '{1'b0, 1'b1, 1'b1};
  bit mode [3] = '{1'b1, 1'b0, 1'b1};
  bit m_ov [3] = '{0, 0, 0};
  logic [31:0] m_od [3] = '{0, 0, 0};
  logic [3:0] m_pos [3] = '{0, 0, 0};
  int m_idx [3] = '{0, 0, 0};
  int m_ptr [3] = '{0, 0, 0};
  vec_t tv [24];
  always #5 clk = ~clk;
  arb_selector #(.DATA(32), .IN(4), .ACT(HIGH), .MSB(DISABLE), .MODE(HIGH)) u_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_pos(op[0]), .out_idx(oi[0]));
  arb_selector #(.DATA(32), .IN(4), .ACT(HIGH), .MSB(ENABLE), .MODE(LOW)) u_fx (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_pos(op[1]), .out_idx(oi[1]));
  arb_selector #(.DATA(32), .IN(4), .ACT(LOW), .MSB(ENABLE), .MODE(HIGH)) u_al (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_pos(op[2]), .out_idx(oi[2]));
  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s inst%0d: got %0h expected %0h", n, k, a, e);
    end
  endtask
  // Walk lanes one by one from the start point in the search direction; first requester wins
  function automatic int mgrant(input int k);
    int start, c;
    start = mode[k] ? m_ptr[k] : (msb[k] ? 3 : 0);
    for (int j = 0; j < 4; j++) begin
      c = msb[k] ? (start - j + 4) % 4 : (start + j) % 4;
      if (in_valid[c] == act[k]) return c;
    end
    return -1;
  endfunction
  task automatic step(input int hi, input vec_t t);
    int g [3];
    bit ld [3];
    logic [31:0] dat [3];
    #1;
    for (int k = 0; k < 3; k++) begin
      g[k] = mgrant(k);
      ld[k] = !m_ov[k] || out_ready;
      dat[k] = g[k] >= 0 ? in_data[32*g[k] +: 32] : 32'h0;
      chk("in_ready", k, 32'(ir[k]), (!reset && ld[k] && g[k] >= 0) ? 32'(1 << g[k]) : 32'h0);
    end
    if (hi >= 0) chk("tbl_in_ready", hi, 32'(ir[hi]), 32'(t.eir));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_ov[k] = 0; m_od[k] = 0; m_pos[k] = 0; m_idx[k] = 0; m_ptr[k] = 0;
      end else if (ld[k]) begin
        m_ov[k] = g[k] >= 0;
        if (g[k] >= 0) begin
          m_od[k] = dat[k];
          m_pos[k] = 4'(1 << g[k]);
          m_idx[k] = g[k];
          if (mode[k]) m_ptr[k] = msb[k] ? (g[k] + 3) % 4 : (g[k] + 1) % 4;
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
      chk("out_data", k, od[k], m_od[k]);
      chk("out_pos", k, 32'(op[k]), 32'(m_pos[k]));
      chk("out_idx", k, 32'(oi[k]), 32'(m_idx[k]));
    end
    if (hi >= 0) begin
      chk("tbl_out_valid", hi, 32'(ov[hi]), 32'(t.eov));
      chk("tbl_out_data", hi, od[hi], t.ed);
      chk("tbl_out_pos", hi, 32'(op[hi]), 32'(t.epos));
      chk("tbl_out_idx", hi, 32'(oi[hi]), 32'(t.eidx));
    end
  endtask
  initial begin
    tv[0]  = '{0, 1, 4'hf, 1, 4'h0, 0, 0, 4'h0, 0};
    tv[1]  = '{0, 0, 4'hf, 1, 4'h1, 1, 1, 4'h1, 0};
    tv[2]  = '{0, 0, 4'hf, 1, 4'h2, 1, 2, 4'h2, 1};
    tv[3]  = '{0, 0, 4'hf, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[4]  = '{0, 0, 4'hf, 1, 4'h8, 1, 4, 4'h8, 3};
    tv[5]  = '{0, 0, 4'hf, 1, 4'h1, 1, 1, 4'h1, 0};
    tv[6]  = '{0, 0, 4'h4, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[7]  = '{0, 0, 4'h5, 1, 4'h1, 1, 1, 4'h1, 0};
    tv[8]  = '{0, 0, 4'h5, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[9]  = '{0, 0, 4'h5, 1, 4'h1, 1, 1, 4'h1, 0};
    tv[10] = '{0, 0, 4'hf, 0, 4'h0, 1, 1, 4'h1, 0};
    tv[11] = '{0, 0, 4'hf, 0, 4'h0, 1, 1, 4'h1, 0};
    tv[12] = '{0, 0, 4'hf, 0, 4'h0, 1, 1, 4'h1, 0};
    tv[13] = '{0, 0, 4'hf, 1, 4'h2, 1, 2, 4'h2, 1};
    tv[14] = '{0, 0, 4'h0, 1, 4'h0, 0, 2, 4'h2, 1};
    tv[15] = '{0, 0, 4'hf, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[16] = '{0, 1, 4'hf, 1, 4'h0, 0, 0, 4'h0, 0};
    tv[17] = '{0, 0, 4'hf, 1, 4'h1, 1, 1, 4'h1, 0};
    tv[18] = '{1, 1, 4'h6, 1, 4'h0, 0, 0, 4'h0, 0};
    tv[19] = '{1, 0, 4'h6, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[20] = '{1, 0, 4'h6, 1, 4'h4, 1, 3, 4'h4, 2};
    tv[21] = '{1, 0, 4'h2, 1, 4'h2, 1, 2, 4'h2, 1};
    tv[22] = '{2, 1, 4'he, 1, 4'h0, 0, 0, 4'h0, 0};
    tv[23] = '{2, 0, 4'he, 1, 4'h1, 1, 1, 4'h1, 0};
    in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    reset = 1'b1;
    in_valid = 4'h0;
    out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      reset = tv[i].rst;
      in_valid = tv[i].v;
      out_ready = tv[i].rdy;
      step(tv[i].inst, tv[i]);
    end
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 49) == 0;
      in_valid = 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(-1, tv[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
